uart_cmd_parser: RTL and testbench
==================================

UART_CMD_PARSER -- requirements
Module: uart_cmd_parser

Interface
REQ-001 Parameter: LOWER_HEX, default 1, meaning lowercase a-f accepted as hex digits (0: only 0-9, A-F).
REQ-002 clk  input  1  clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 rx_data  input  8  ASCII byte from UART receiver.
REQ-005 rx_valid  input  1  rx_data valid.
REQ-006 rx_ready  output  1  parser accepts byte; byte consumed when rx_valid && rx_ready on a rising edge.
REQ-007 cmd_valid  output  1  decoded command presented.
REQ-008 cmd_ready  input  1  consumer accepts command; transfer when cmd_valid && cmd_ready.
REQ-009 cmd_write  output  1  1 = write command, 0 = read command.
REQ-010 cmd_addr  output  32  decoded address.
REQ-011 cmd_wdata  output  32  decoded write data (0 for reads).
REQ-012 parse_err  output  1  one-cycle pulse on malformed input.

Function
REQ-013 Grammar: "R" SP 8hex EOL (read); "W" SP 8hex SP 8hex EOL (write); SP = 0x20, EOL = optional CR (0x0D) then LF (0x0A); hex is MSB nibble first.
REQ-014 States: S_IDLE, S_SP1, S_ADDR, S_SP2, S_DATA, S_EOL, S_ISSUE, S_SKIP.
REQ-015 S_IDLE: 'R' -> S_SP1 (write flag 0); 'W' -> S_SP1 (write flag 1); CR/LF ignored, stay; other byte -> error.
REQ-016 S_SP1: SP -> S_ADDR with digit counter 0; else error.
REQ-017 S_ADDR: hex digit shifts into address (addr <= {addr[27:0], nibble}), counter +1; after 8th digit -> S_SP2 if write else S_EOL; non-hex -> error.
REQ-018 S_SP2: SP -> S_DATA with counter 0 and data cleared; else error; S_DATA mirrors S_ADDR into data register, 8th digit -> S_EOL.
REQ-019 S_EOL: CR stays (at most one CR; second CR -> error); LF -> S_ISSUE; else error.
REQ-020 Address and data registers cleared on leaving S_IDLE so a read issues cmd_wdata = 0.
REQ-021 S_ISSUE: cmd_valid = 1, rx_ready = 0; cmd_addr/cmd_wdata/cmd_write stable while cmd_valid high; on cmd_ready -> S_IDLE, cmd_valid low next cycle.
REQ-022 Latency: cmd_valid asserts the cycle after the LF byte is consumed.
REQ-023 rx_ready = 1 in every state except S_ISSUE.
REQ-024 Error: parse_err high for exactly the cycle after the offending byte is consumed; offending byte LF -> S_IDLE, otherwise -> S_SKIP.
REQ-025 S_SKIP: discards bytes until LF, then -> S_IDLE; no further parse_err while in S_SKIP.
REQ-026 No byte is consumed and no command lost while cmd_valid waits; back-pressure holds the upstream byte.
REQ-027 Digit counter 4-bit, never wraps: exactly 8 digits per field; fewer then SP/LF, or 9th digit, is an error.
REQ-028 With LOWER_HEX = 0, 'a'-'f' are errors.

Reset
REQ-029 On rst low: state S_IDLE, cmd_valid 0, cmd_write 0, cmd_addr 0, cmd_wdata 0, parse_err 0, counter 0; rx_ready is 1 from the first cycle after release.
REQ-030 Reset during S_ISSUE drops the pending command with no handshake.

Structure
REQ-031 State encoding and ASCII constants (SP, CR, LF, 'R', 'W') reside in a shared package, uart_pkg, used by the UART logger and the parser.
REQ-032 One sub-module, hex_nibble_dec: combinational ASCII-to-nibble with a valid flag, parameterised by LOWER_HEX.

Verification
REQ-033 "R 1000ABCD\n", cmd_ready = 1 -> one cmd_valid pulse, cmd_write = 0, cmd_addr = 0x1000ABCD, cmd_wdata = 0, parse_err never high.
REQ-034 "W 80000004 deadbeef\r\n", cmd_ready held 0 for 5 cycles -> cmd_valid held 5+ cycles with stable cmd_addr = 0x80000004, cmd_wdata = 0xDEADBEEF, cmd_write = 1; rx_ready 0 throughout; one transfer.
REQ-035 "R 12G45678\nR 00000010\n" -> parse_err one pulse after 'G'; rest discarded; then read cmd_addr = 0x00000010.
REQ-036 "R 1234\n" -> parse_err on LF, direct return to S_IDLE, no cmd_valid; following "\n\n" ignored with no error.
REQ-037 LOWER_HEX = 0, "W 0000000a 00000001\n" -> parse_err, no command.
REQ-038 rst asserted in S_DATA after 4 digits, then "R FFFFFFFF\n" -> outputs at reset values, then read cmd_addr = 0xFFFFFFFF.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: command parser state encoding and ASCII framing constants.
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SP1,
    S_ADDR,
    S_SP2,
    S_DATA,
    S_EOL,
    S_ISSUE,
    S_SKIP
  } parser_state_t;

  localparam logic [7:0] ASCII_SP = 8'h20;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_R  = 8'h52;
  localparam logic [7:0] ASCII_W  = 8'h57;

  localparam logic [3:0] LAST_DIGIT_IDX = 4'd7;

  function automatic logic is_eol_char(input logic [7:0] c);
    return (c == ASCII_CR) || (c == ASCII_LF);
  endfunction

endpackage

// File: rtl/hex_nibble_dec.sv
// Combinational ASCII hex digit decoder; valid is low for any non-hex character.
module hex_nibble_dec #(
  parameter bit LOWER_HEX = 1'b1
) (
  input  logic [7:0] ascii,
  output logic [3:0] nibble,
  output logic       valid
);

  always_comb begin
    nibble = 4'h0;
    valid  = 1'b0;
    if (ascii >= 8'h30 && ascii <= 8'h39) begin
      nibble = ascii[3:0];
      valid  = 1'b1;
    end else if (ascii >= 8'h41 && ascii <= 8'h46) begin
      // 'A'..'F' and 'a'..'f' have low nibbles 1..6
      nibble = ascii[3:0] + 4'd9;
      valid  = 1'b1;
    end else if (LOWER_HEX && ascii >= 8'h61 && ascii <= 8'h66) begin
      nibble = ascii[3:0] + 4'd9;
      valid  = 1'b1;
    end
  end

endmodule

// File: rtl/uart_cmd_parser.sv
// ASCII command line parser: "R aaaaaaaa" / "W aaaaaaaa dddddddd" terminated by [CR]LF,
// presented as a valid/ready command beat; malformed lines pulse parse_err and are discarded.
module uart_cmd_parser
  import uart_pkg::*;
#(
  parameter bit LOWER_HEX = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic        cmd_write,
  output logic [31:0] cmd_addr,
  output logic [31:0] cmd_wdata,
  output logic        parse_err
);

  parser_state_t state_q, state_d;
  logic          write_q, write_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   data_q, data_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          cr_q, cr_d;
  logic          err_q, err_d;

  logic [3:0] nibble;
  logic       nibble_valid;
  logic       byte_fire;
  logic       bad_byte;

  hex_nibble_dec #(
    .LOWER_HEX(LOWER_HEX)
  ) u_hex_dec (
    .ascii (rx_data),
    .nibble(nibble),
    .valid (nibble_valid)
  );

  assign rx_ready  = (state_q != S_ISSUE);
  assign byte_fire = rx_valid && rx_ready;
  assign cmd_valid = (state_q == S_ISSUE);
  assign cmd_write = write_q;
  assign cmd_addr  = addr_q;
  assign cmd_wdata = data_q;
  assign parse_err = err_q;

  always_comb begin
    state_d  = state_q;
    write_d  = write_q;
    addr_d   = addr_q;
    data_d   = data_q;
    cnt_d    = cnt_q;
    cr_d     = cr_q;
    err_d    = 1'b0;
    bad_byte = 1'b0;

    if (state_q == S_ISSUE && cmd_ready) begin
      state_d = S_IDLE;
    end

    if (byte_fire) begin
      case (state_q)
        S_IDLE: begin
          if (rx_data == ASCII_R || rx_data == ASCII_W) begin
            state_d = S_SP1;
            write_d = (rx_data == ASCII_W);
            addr_d  = 32'h0;
            data_d  = 32'h0;
          end else if (!is_eol_char(rx_data)) begin
            bad_byte = 1'b1;
          end
        end
        S_SP1: begin
          if (rx_data == ASCII_SP) begin
            state_d = S_ADDR;
            cnt_d   = 4'd0;
          end else begin
            bad_byte = 1'b1;
          end
        end
        S_ADDR: begin
          if (nibble_valid) begin
            addr_d = {addr_q[27:0], nibble};
            cnt_d  = cnt_q + 4'd1;
            if (cnt_q == LAST_DIGIT_IDX) begin
              state_d = write_q ? S_SP2 : S_EOL;
              cr_d    = 1'b0;
            end
          end else begin
            bad_byte = 1'b1;
          end
        end
        S_SP2: begin
          if (rx_data == ASCII_SP) begin
            state_d = S_DATA;
            cnt_d   = 4'd0;
            data_d  = 32'h0;
          end else begin
            bad_byte = 1'b1;
          end
        end
        S_DATA: begin
          if (nibble_valid) begin
            data_d = {data_q[27:0], nibble};
            cnt_d  = cnt_q + 4'd1;
            if (cnt_q == LAST_DIGIT_IDX) begin
              state_d = S_EOL;
              cr_d    = 1'b0;
            end
          end else begin
            bad_byte = 1'b1;
          end
        end
        S_EOL: begin
          if (rx_data == ASCII_CR && !cr_q) begin
            cr_d = 1'b1;
          end else if (rx_data == ASCII_LF) begin
            state_d = S_ISSUE;
          end else begin
            bad_byte = 1'b1;
          end
        end
        S_SKIP: begin
          if (rx_data == ASCII_LF) begin
            state_d = S_IDLE;
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end

    // An offending LF already ends the line, so only other bytes need resynchronising.
    if (bad_byte) begin
      err_d   = 1'b1;
      state_d = (rx_data == ASCII_LF) ? S_IDLE : S_SKIP;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      write_q <= 1'b0;
      addr_q  <= 32'h0;
      data_q  <= 32'h0;
      cnt_q   <= 4'd0;
      cr_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      cr_q    <= cr_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser: default instance plus an uppercase-only instance.
module tb_uart_cmd_parser;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_valid_nl = 1'b0;
  logic        cmd_ready = 1'b0;
  logic        cmd_ready_nl = 1'b1;

  logic        rx_ready, cmd_valid, cmd_write, parse_err;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rx_ready_nl, cmd_valid_nl, cmd_write_nl, parse_err_nl;
  logic [31:0] cmd_addr_nl, cmd_wdata_nl;

  int vectors = 0;
  int miscompares = 0;
  int xfer_cnt = 0;
  int err_cnt = 0;
  int xfer_nl_cnt = 0;
  int err_nl_cnt = 0;
  int xfer_base, err_base;

  always #5 clk = ~clk;

  uart_cmd_parser dut (
    .clk      (clk),
    .rst      (rst),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_addr (cmd_addr),
    .cmd_wdata(cmd_wdata),
    .parse_err(parse_err)
  );

  uart_cmd_parser #(.LOWER_HEX(1'b0)) dut_nl (
    .clk      (clk),
    .rst      (rst),
    .rx_data  (rx_data),
    .rx_valid (rx_valid_nl),
    .rx_ready (rx_ready_nl),
    .cmd_valid(cmd_valid_nl),
    .cmd_ready(cmd_ready_nl),
    .cmd_write(cmd_write_nl),
    .cmd_addr (cmd_addr_nl),
    .cmd_wdata(cmd_wdata_nl),
    .parse_err(parse_err_nl)
  );

  always @(posedge clk) begin
    if (cmd_valid && cmd_ready) xfer_cnt <= xfer_cnt + 1;
    if (parse_err) err_cnt <= err_cnt + 1;
    if (cmd_valid_nl && cmd_ready_nl) xfer_nl_cnt <= xfer_nl_cnt + 1;
    if (parse_err_nl) err_nl_cnt <= err_nl_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drives one byte at a negedge and holds it until the selected parser consumes it.
  task automatic send_byte(input logic [7:0] b, input bit sel);
    int n;
    n = 0;
    @(negedge clk);
    rx_data = b;
    if (sel) rx_valid_nl = 1'b1; else rx_valid = 1'b1;
    while (!(sel ? rx_ready_nl : rx_ready) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      vectors++;
      miscompares++;
      $display("FAIL rx_timeout observed=rx_ready low expected=high byte=%h", b);
    end
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rx_valid_nl = 1'b0;
    $display("byte %h sent to %s", b, sel ? "dut_nl" : "dut");
  endtask

  task automatic send_str(input string s, input bit sel);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], sel);
  endtask

  task automatic mark();
    xfer_base = xfer_cnt;
    err_base  = err_cnt;
  endtask

  initial begin
    // Reset values
    repeat (3) @(negedge clk);
    check("rst_cmd_valid", {31'b0, cmd_valid}, 32'd0);
    check("rst_cmd_write", {31'b0, cmd_write}, 32'd0);
    check("rst_cmd_addr", cmd_addr, 32'h0);
    check("rst_cmd_wdata", cmd_wdata, 32'h0);
    check("rst_parse_err", {31'b0, parse_err}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("rst_rx_ready", {31'b0, rx_ready}, 32'd1);

    // Plain read with consumer always ready
    cmd_ready = 1'b1;
    mark();
    send_str("R 1000ABCD\n", 1'b0);
    check("rd_latency_valid", {31'b0, cmd_valid}, 32'd1);
    check("rd_addr", cmd_addr, 32'h1000ABCD);
    check("rd_write", {31'b0, cmd_write}, 32'd0);
    check("rd_wdata", cmd_wdata, 32'h0);
    repeat (2) @(negedge clk);
    check("rd_xfers", xfer_cnt - xfer_base, 32'd1);
    check("rd_errs", err_cnt - err_base, 32'd0);
    check("rd_valid_drop", {31'b0, cmd_valid}, 32'd0);

    // Write with CR LF and consumer stalled for 5 cycles
    cmd_ready = 1'b0;
    mark();
    send_str("W 80000004 deadbeef", 1'b0);
    send_byte(8'h0D, 1'b0);
    send_byte(8'h0A, 1'b0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("wr_hold_valid", {31'b0, cmd_valid}, 32'd1);
      check("wr_hold_addr", cmd_addr, 32'h80000004);
      check("wr_hold_wdata", cmd_wdata, 32'hDEADBEEF);
      check("wr_hold_write", {31'b0, cmd_write}, 32'd1);
      check("wr_hold_rx_ready", {31'b0, rx_ready}, 32'd0);
    end
    cmd_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("wr_xfers", xfer_cnt - xfer_base, 32'd1);
    check("wr_errs", err_cnt - err_base, 32'd0);
    check("wr_valid_drop", {31'b0, cmd_valid}, 32'd0);

    // Bad hex digit: one error, rest of line discarded, next line works
    mark();
    send_str("R 12G", 1'b0);
    check("badhex_err_pulse", {31'b0, parse_err}, 32'd1);
    send_str("45678\n", 1'b0);
    repeat (2) @(negedge clk);
    check("badhex_no_cmd", xfer_cnt - xfer_base, 32'd0);
    send_str("R 00000010\n", 1'b0);
    check("badhex_next_addr", cmd_addr, 32'h00000010);
    repeat (2) @(negedge clk);
    check("badhex_errs", err_cnt - err_base, 32'd1);
    check("badhex_xfers", xfer_cnt - xfer_base, 32'd1);

    // Short address ending in LF, then blank lines
    mark();
    send_str("R 1234\n", 1'b0);
    check("short_err_on_lf", {31'b0, parse_err}, 32'd1);
    send_str("\n\n", 1'b0);
    repeat (2) @(negedge clk);
    check("short_errs", err_cnt - err_base, 32'd1);
    check("short_no_cmd", xfer_cnt - xfer_base, 32'd0);
    // LF error returns straight to idle, so the very next line parses
    mark();
    send_str("R 1234\n", 1'b0);
    send_str("R 00000020\n", 1'b0);
    check("short_direct_addr", cmd_addr, 32'h00000020);
    check("short_direct_valid", {31'b0, cmd_valid}, 32'd1);
    repeat (2) @(negedge clk);
    check("short_direct_xfers", xfer_cnt - xfer_base, 32'd1);

    // Ninth digit is an error
    mark();
    send_str("R 12345678", 1'b0);
    send_byte(8'h39, 1'b0);
    check("ninth_digit_err", {31'b0, parse_err}, 32'd1);
    send_str("\n", 1'b0);
    repeat (2) @(negedge clk);
    check("ninth_no_cmd", xfer_cnt - xfer_base, 32'd0);

    // Lowercase accepted by default instance
    mark();
    send_str("W 0000000a 00000001\n", 1'b0);
    check("lc_addr", cmd_addr, 32'h0000000A);
    check("lc_wdata", cmd_wdata, 32'h00000001);
    repeat (2) @(negedge clk);
    check("lc_xfers", xfer_cnt - xfer_base, 32'd1);

    // Lowercase rejected by uppercase-only instance
    send_str("W 0000000a", 1'b1);
    check("nl_err_pulse", {31'b0, parse_err_nl}, 32'd1);
    send_str(" 00000001\n", 1'b1);
    repeat (2) @(negedge clk);
    check("nl_errs", err_nl_cnt, 32'd1);
    check("nl_no_cmd", xfer_nl_cnt, 32'd0);

    // Reset in the middle of the data field
    send_str("W 12345678 ABCD", 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_write", {31'b0, cmd_write}, 32'd0);
    check("midrst_addr", cmd_addr, 32'h0);
    check("midrst_wdata", cmd_wdata, 32'h0);
    check("midrst_valid", {31'b0, cmd_valid}, 32'd0);
    check("midrst_err", {31'b0, parse_err}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_rx_ready", {31'b0, rx_ready}, 32'd1);
    mark();
    send_str("R FFFFFFFF\n", 1'b0);
    check("midrst_rd_addr", cmd_addr, 32'hFFFFFFFF);
    check("midrst_rd_write", {31'b0, cmd_write}, 32'd0);
    check("midrst_rd_wdata", cmd_wdata, 32'h0);
    repeat (2) @(negedge clk);
    check("midrst_rd_xfers", xfer_cnt - xfer_base, 32'd1);
    check("midrst_rd_errs", err_cnt - err_base, 32'd0);

    // Reset while a command is pending drops it
    cmd_ready = 1'b0;
    mark();
    send_str("R 00000001\n", 1'b0);
    check("issue_rst_pending", {31'b0, cmd_valid}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("issue_rst_valid", {31'b0, cmd_valid}, 32'd0);
    cmd_ready = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("issue_rst_xfers", xfer_cnt - xfer_base, 32'd0);
    check("issue_rst_idle_valid", {31'b0, cmd_valid}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
